// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus sequencer and related bus controllers.
package reg_bus_pkg;

    // Width of the shared register data bus.
    localparam int REG_W = 16;

    // Largest register count the decode helper can address.
    localparam int MAX_NREG = 256;

    // Transfer sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } bus_state_t;

    // Register index to one-hot enable vector; all-zero when the index
    // does not name a register that exists on the bus.
    function automatic logic [MAX_NREG-1:0] onehot_decode(
        input int unsigned idx,
        input int unsigned nreg
    );
        logic [MAX_NREG-1:0] vec;
        vec = '0;
        if ((idx < nreg) && (idx < MAX_NREG)) begin
            vec[idx[7:0]] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past rr_ptr and
// wraps, so the most recently served requester has the lowest priority.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] rr_ptr,
    output logic [PTRW-1:0] winner,
    output logic            any_req
);

    // Rotate requests so bit 0 is the first candidate, then take the lowest set bit.
    always_comb begin
        logic [NREQ-1:0] rot;
        int              off;
        int              win_int;
        rot     = NREQ'({req, req} >> (int'(rr_ptr) + 1));
        off     = 0;
        any_req = 1'b0;
        // Scanning downwards leaves the lowest set offset as the final assignment.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off     = k;
                any_req = 1'b1;
            end
        end
        win_int = (int'(rr_ptr) + 1 + off) % NREQ;
        winner  = PTRW'(win_int);
    end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Register-bus sequencer: arbitrates register-to-register moves between
// requesters and drives the source LDBUS and destination WR enables in order.
module reg_bus_sequencer #(
    parameter int NREQ = 4,
    parameter int NREG = 16,
    parameter int IDXW = 4
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*IDXW-1:0] src_idx,
    input  logic [NREQ*IDXW-1:0] dst_idx,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [NREG-1:0]      ldbus,
    output logic [NREG-1:0]      wr,
    output logic                 busy
);
    import reg_bus_pkg::*;

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDXW-1:0] src_arr [NREQ];
    logic [IDXW-1:0] dst_arr [NREQ];

    bus_state_t      state_reg;
    logic [PTRW-1:0] rr_ptr_reg;
    logic [PTRW-1:0] win_reg;
    logic [NREG-1:0] wr_pend_reg;
    logic [NREQ-1:0] grant_reg;
    logic [NREQ-1:0] done_reg;
    logic [NREG-1:0] ldbus_reg;
    logic [NREG-1:0] wr_reg;
    logic            busy_reg;

    logic [PTRW-1:0] winner;
    logic            any_req;
    logic [NREG-1:0] win_src_dec;
    logic [NREG-1:0] win_dst_dec;
    logic            win_legal;

    // Unpack the per-requester index fields.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign src_arr[gi] = src_idx[gi*IDXW +: IDXW];
            assign dst_arr[gi] = dst_idx[gi*IDXW +: IDXW];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr_reg),
        .winner  (winner),
        .any_req (any_req)
    );

    // Decode the winner's indices; a move is legal only if both name real registers,
    // so an out-of-range index can never put garbage onto a real register.
    always_comb begin
        win_src_dec = NREG'(onehot_decode(32'(src_arr[winner]), NREG));
        win_dst_dec = NREG'(onehot_decode(32'(dst_arr[winner]), NREG));
        win_legal   = (|win_src_dec) && (|win_dst_dec);
    end

    // Transfer sequencer with registered grant/done/enable outputs.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= PTRW'(NREQ - 1);
            win_reg     <= '0;
            wr_pend_reg <= '0;
            grant_reg   <= '0;
            done_reg    <= '0;
            ldbus_reg   <= '0;
            wr_reg      <= '0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= '0;
                    wr_reg   <= '0;
                    if (any_req) begin
                        win_reg     <= winner;
                        rr_ptr_reg  <= winner;
                        grant_reg   <= NREQ'(1) << winner;
                        ldbus_reg   <= win_legal ? win_src_dec : '0;
                        wr_pend_reg <= win_legal ? win_dst_dec : '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= DRIVE;
                    end else begin
                        busy_reg    <= 1'b0;
                    end
                end
                DRIVE: begin
                    // Source keeps driving; destination write enable joins it.
                    wr_reg    <= wr_pend_reg;
                    state_reg <= WRITE;
                end
                WRITE: begin
                    grant_reg <= '0;
                    ldbus_reg <= '0;
                    wr_reg    <= '0;
                    done_reg  <= NREQ'(1) << win_reg;
                    state_reg <= DONE;
                end
                DONE: begin
                    done_reg  <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    grant_reg <= '0;
                    done_reg  <= '0;
                    ldbus_reg <= '0;
                    wr_reg    <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign grant = grant_reg;
    assign done  = done_reg;
    assign ldbus = ldbus_reg;
    assign wr    = wr_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Scoreboard bench for reg_bus_sequencer. NREG=12 with 4-bit indices so that
// indices 12..15 exercise the illegal-request path; a behavioural register
// bank hangs off ldbus/wr and is checked against a transaction-level copy.
module tb_reg_bus_sequencer;

    localparam int NREQ = 4;
    localparam int NREG = 12;
    localparam int IDXW = 4;

    logic                 clk = 1'b0;
    logic                 RST = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*IDXW-1:0] src_idx = '0;
    logic [NREQ*IDXW-1:0] dst_idx = '0;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      done;
    logic [NREG-1:0]      ldbus;
    logic [NREG-1:0]      wr;
    logic                 busy;

    always #5 clk = ~clk;

    reg_bus_sequencer #(
        .NREQ (NREQ),
        .NREG (NREG),
        .IDXW (IDXW)
    ) dut (
        .clk     (clk),
        .RST     (RST),
        .req     (req),
        .src_idx (src_idx),
        .dst_idx (dst_idx),
        .grant   (grant),
        .done    (done),
        .ldbus   (ldbus),
        .wr      (wr),
        .busy    (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int w;
        int s;
        int d;
    } xfer_t;

    xfer_t exp_q[$];
    int    grant_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req_v, $time);
        end
    endtask

    function automatic bit legal(input int s, input int d);
        return (s < NREG) && (d < NREG);
    endfunction

    function automatic logic [NREG-1:0] en_vec(input int idx, input bit ok);
        logic [NREG-1:0] v;
        v = '0;
        if (ok) v = NREG'(1) << idx;
        return v;
    endfunction

    function automatic logic [15:0] init_val(input int k);
        return 16'(k * 16'h1357 + 16'h00A5);
    endfunction

    // Behavioural register bank driven by the DUT's enables.
    logic [15:0] bank [NREG];
    logic [15:0] ref_regs [NREG];
    logic [15:0] bus_val;

    always_comb begin
        bus_val = '0;
        for (int k = 0; k < NREG; k++) if (ldbus[k]) bus_val = bus_val | bank[k];
    end

    always @(posedge clk) begin
        for (int k = 0; k < NREG; k++) begin
            if (!RST)       bank[k] <= init_val(k);
            else if (wr[k]) bank[k] <= bus_val;
        end
    end

    // Reference model: a transfer is accepted when the model is free, the winner
    // is the first requester after the last served one, and each move takes 4 cycles.
    int m_last = NREQ - 1;
    int m_cnt  = 0;
    int m_c;
    always @(posedge clk) begin
        if (!RST) begin
            m_last = NREQ - 1;
            m_cnt  = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
        end else if (req != 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                m_c = (m_last + k) % NREQ;
                if (req[m_c]) begin
                    exp_q.push_back('{m_c, int'(src_idx[m_c*IDXW +: IDXW]),
                                           int'(dst_idx[m_c*IDXW +: IDXW])});
                    m_last = m_c;
                    m_cnt  = 3;
                    break;
                end
            end
        end
    end

    // Monitor: pops an expected transfer when the DUT grants and follows it through.
    int    ph = 0;
    xfer_t cur;
    always @(negedge clk) begin
        chk("onehot_ldbus", 32'($onehot0(ldbus)), 1);
        chk("onehot_wr", 32'($onehot0(wr)), 1);
        chk("onehot_grant", 32'($onehot0(grant)), 1);
        chk("grant_implies_busy", 32'((grant != 0) && !busy), 0);
        if (!RST) begin
            chk("reset_outputs", 32'({grant, done, ldbus, wr, busy}), 0);
            ph = 0;
            exp_q.delete();
            for (int k = 0; k < NREG; k++) ref_regs[k] = init_val(k);
        end else begin
            case (ph)
                0: begin
                    if (grant != 0) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_grant", 32'(grant), 0);
                        end else begin
                            cur = exp_q.pop_front();
                            grant_log.push_back(cur.w);
                            chk("drive_grant", 32'(grant), 32'(1) << cur.w);
                            chk("drive_ldbus", 32'(ldbus), 32'(en_vec(cur.s, legal(cur.s, cur.d))));
                            chk("drive_wr", 32'(wr), 0);
                            chk("drive_busy_done", 32'({busy, done}), 32'h10);
                            ph = 1;
                        end
                    end else begin
                        chk("idle_outputs", 32'({done, ldbus, wr, busy}), 0);
                        if (exp_q.size() != 0) begin
                            chk("grant_missing", 32'(grant), 32'(1) << exp_q[0].w);
                            void'(exp_q.pop_front());
                        end
                    end
                end
                1: begin
                    chk("write_grant", 32'(grant), 32'(1) << cur.w);
                    chk("write_ldbus", 32'(ldbus), 32'(en_vec(cur.s, legal(cur.s, cur.d))));
                    chk("write_wr", 32'(wr), 32'(en_vec(cur.d, legal(cur.s, cur.d))));
                    chk("write_busy_done", 32'({busy, done}), 32'h10);
                    ph = 2;
                end
                default: begin
                    chk("done_pulse", 32'(done), 32'(1) << cur.w);
                    chk("done_enables", 32'({grant, ldbus, wr}), 0);
                    chk("done_busy", 32'(busy), 1);
                    if (legal(cur.s, cur.d)) begin
                        ref_regs[cur.d] = ref_regs[cur.s];
                        chk("bank_dst", 32'(bank[cur.d]), 32'(ref_regs[cur.d]));
                    end
                    ph = 0;
                end
            endcase
        end
    end

    // One directed move: request in an idle cycle, optionally change src after sampling.
    task automatic move(input int i, input int s, input int d, input int new_s);
        int t;
        @(posedge clk); #1;
        src_idx[i*IDXW +: IDXW] = IDXW'(s);
        dst_idx[i*IDXW +: IDXW] = IDXW'(d);
        req[i] = 1'b1;
        @(posedge clk); #1;
        if (new_s >= 0) src_idx[i*IDXW +: IDXW] = IDXW'(new_s);
        t = 0;
        while (!done[i] && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("move_latency", 32'(t), 2);
        $display("move req=%0d src=%0d dst=%0d edges_to_done=%0d", i, s, d, t);
        req[i] = 1'b0;
    endtask

    initial begin
        int t;
        // Reset held with all requesting: outputs must stay zero.
        req = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", 32'({grant, done, ldbus, wr, busy}), 0);
        for (int i = 0; i < NREQ; i++) begin
            src_idx[i*IDXW +: IDXW] = IDXW'(i + 1);
            dst_idx[i*IDXW +: IDXW] = IDXW'(i + 5);
        end
        grant_log.delete();
        RST = 1'b1;
        repeat (16) @(posedge clk);
        #1 req = '0;
        repeat (4) @(posedge clk);
        chk("rr_count", 32'(grant_log.size()), 4);
        for (int k = 0; k < grant_log.size(); k++) chk("rr_order", 32'(grant_log[k]), 32'(k));
        $display("round-robin grants observed: %0d", grant_log.size());

        move(2, 5, 9, -1);
        move(1, 3, 4, 7);
        move(0, 2, 13, -1);
        move(3, 14, 1, -1);
        move(1, 6, 6, -1);
        move(3, 11, 0, -1);

        // Reset asserted during WRITE: enables drop without a clock edge.
        @(posedge clk); #1;
        src_idx[2*IDXW +: IDXW] = 4'd1;
        dst_idx[2*IDXW +: IDXW] = 4'd2;
        req[2] = 1'b1;
        t = 0;
        while (grant == 0 && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        chk("abort_in_write", 32'(wr), 32'(en_vec(2, 1'b1)));
        #1 RST = 1'b0;
        #1 chk("abort_async", 32'({grant, done, ldbus, wr, busy}), 0);
        req = '0;
        repeat (2) @(posedge clk);
        #1 RST = 1'b1;
        $display("async reset during WRITE applied");

        // Pointer back at NREQ-1 after reset: requester 0 wins first.
        grant_log.delete();
        req = '1;
        @(posedge clk); #1 req = '0;
        repeat (5) @(posedge clk);
        chk("post_reset_first", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 0);

        // Randomised traffic obeying the hold-until-done contract.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        src_idx[i*IDXW +: IDXW] = IDXW'($urandom_range(0, 15));
                        dst_idx[i*IDXW +: IDXW] = IDXW'($urandom_range(0, 15));
                    end
                end else if (done[i] && $urandom_range(0, 1) == 0) begin
                    req[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    src_idx[i*IDXW +: IDXW] = IDXW'($urandom_range(0, 15));
                    dst_idx[i*IDXW +: IDXW] = IDXW'($urandom_range(0, 15));
                end
            end
        end
        req = '0;
        repeat (8) @(posedge clk);
        #1;
        chk("drain_queue", 32'(exp_q.size()), 0);
        chk("drain_phase", 32'(ph), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bus_sequencer.md
Name: reg_bus_sequencer

Overview:
- Shares the 16-bit register bus between NREQ requesters (cores or control units).
- Each request is one register-to-register move (src -> dst). The block drives the one-hot LDBUS enable of the source register and the one-hot WR enable of the destination register in the correct cycle order.
- Round-robin arbitration between requesters; one transfer in flight at a time.
- Sits between the core control units and the register bank, replacing direct LDBUS/WR driving by the cores.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NREG, 16, number of registers on the bus
- IDXW, 4, register index width; must satisfy 2**IDXW >= NREG

Ports:
- clk  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester transfer request, level
- src_idx  in  NREQ*IDXW  packed source register index; requester i uses bits [i*IDXW +: IDXW]
- dst_idx  in  NREQ*IDXW  packed destination register index, same packing
- grant  out  NREQ  one-hot, high while the requester's transfer is in flight
- done  out  NREQ  one-hot, single-cycle completion pulse
- ldbus  out  NREG  one-hot register LDBUS enables
- wr  out  NREG  one-hot register WR enables
- busy  out  1  high whenever state != IDLE

Behaviour:
- All outputs are registered. While RST=0: state=IDLE, rr_ptr=NREQ-1, and grant, done, ldbus, wr and busy are all 0, asserted immediately without waiting for a clock.
- FSM states: IDLE, DRIVE, WRITE, DONE.
- IDLE:
  - If any req is high, pick the winner by round-robin. The search starts at (rr_ptr+1) mod NREQ and wraps.
  - Latch the winner's src_idx/dst_idx internally, set rr_ptr = winner, and go to DRIVE.
  - If no req is high, stay in IDLE.
- DRIVE (1 cycle):
  - grant[w]=1, ldbus[src]=1, wr=0; the bus settles.
  - Next state: WRITE.
- WRITE (1 cycle):
  - grant[w]=1, ldbus[src]=1, wr[dst]=1.
  - The destination captures the bus on the rising edge that ends this cycle.
  - Next state: DONE.
- DONE (1 cycle):
  - done[w]=1, grant=0, ldbus=0, wr=0.
  - Next state: IDLE.
- Timing:
  - Latency from req sampled in IDLE (cycle 0) to done pulse is 3 cycles (done high in cycle 3).
  - Each transfer occupies 4 cycles, including the IDLE arbitration cycle.
- Requester contract:
  - Hold req until done; drop req in the cycle done is seen, or keep it high to request another transfer.
  - src_idx/dst_idx changes after the IDLE sampling edge are ignored, because they are latched.
  - req falling during DRIVE or WRITE does not abort the transfer; it completes and done still pulses.
- Round-robin:
  - A requester that holds req continuously is re-arbitrated against the others.
  - With all NREQ requesting, grants rotate 0,1,2,3,0,...
- Index rules:
  - src==dst is legal; the register reloads its own value.
  - An index >= NREG is an illegal request: it is still granted, but ldbus/wr stay all-zero, and done still pulses so the requester cannot hang.
- Mutual exclusion: at most one ldbus bit and at most one wr bit are high in any cycle, and there is never a grant without busy.
- Reset mid-transfer: ldbus/wr drop asynchronously, no done pulse is issued, and rr_ptr returns to NREQ-1.

Decomposition:
- Shared package reg_bus_pkg holds:
  - the state enum (IDLE, DRIVE, WRITE, DONE);
  - the REG_W=16 bus width constant;
  - the onehot_decode function (index -> NREG one-hot, zero if out of range).
- Sub-module rr_arbiter: inputs req[NREQ] and rr_ptr; outputs winner index and any_req. Purely combinational, reusable by other shared-resource controllers.
- The FSM, index latches and output registers stay in reg_bus_sequencer.

Test Plan:
- Reset: hold RST=0 with req=4'b1111 -> all outputs 0 and busy=0. Release RST -> requester 0 is granted first.
- Single move: req[2]=1, src=5, dst=9 at cycle 0 -> cycle 1 ldbus=16'h0020, wr=0. Cycle 2 ldbus=16'h0020, wr=16'h0200. Cycle 3 done=4'b0100, all enables 0. Scoreboard register 9 equals register 5.
- Round-robin: req=4'b1111 held for 16 cycles -> grant sequence 0,1,2,3. Exactly one done per 4 cycles, in the same order.
- Latching: req[1], src=3, dst=4; change src to 7 in cycle 1 -> ldbus stays 16'h0008 through WRITE.
- Abort and illegal index: RST=0 during WRITE -> wr clears without waiting for a clock edge and no done pulse is issued. Separately, NREG=12 with dst=13 -> wr never asserts and done still pulses at cycle 3.
- One-hot checker: random req/src/dst for 10k cycles -> ldbus and wr are always $onehot0, grant is always $onehot0, and grant implies busy.
